// File: rtl/cosim_commit_pkg.sv
// cosim_commit_pkg: retirement record layout, FSM encoding and counter width shared by the commit collector.
package cosim_commit_pkg;

    localparam int DROP_CNT_W = 16;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] insn;
        logic [4:0]  rd;
        logic        rd_we;
        logic [63:0] rd_wdata;
        logic        trap;
        logic [5:0]  cause;
    } commit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HANG  = 2'd3
    } state_e;

endpackage

// File: rtl/cosim_commit_fifo.sv
// cosim_commit_fifo: single-clock FIFO for one core's retirement records.
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/data_i write side;
// pop_i/data_o read side (data_o shows the head); full_o/empty_o status.
// A push while full is accepted when a pop happens in the same cycle.
module cosim_commit_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);

    T               mem_q [DEPTH];
    logic [AW:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic           do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_o = wptr_q == rptr_q;
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign data_o  = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        wptr_d  = wptr_q + (AW+1)'(do_push);
        rptr_d  = rptr_q + (AW+1)'(do_pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/cosim_commit_collector.sv
// cosim_commit_collector: buffers per-core retirement records and serialises them round-robin onto one stream.
// Ports: clk_i/rst_ni clock and async active-low reset; enable_i capture enable;
// commit_valid_i/commit_i per-core retirement strobes and records;
// out_valid_o/out_ready_i/out_core_o/out_commit_o registered output stream;
// overflow_o sticky per-core drop flags; drop_cnt_o saturating drop total;
// hang_o sticky watchdog expiry; state_o FSM state.
module cosim_commit_collector
    import cosim_commit_pkg::*;
#(
    parameter int  NUM_CORES   = 1,
    parameter int  FIFO_DEPTH  = 8,
    parameter int  WDOG_CYCLES = 100000,
    localparam int CW          = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
    localparam int WW          = $clog2(WDOG_CYCLES + 1)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            enable_i,
    input  logic [NUM_CORES-1:0]            commit_valid_i,
    input  commit_t [NUM_CORES-1:0]         commit_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [CW-1:0]                   out_core_o,
    output commit_t                         out_commit_o,
    output logic [NUM_CORES-1:0]            overflow_o,
    output logic [DROP_CNT_W-1:0]           drop_cnt_o,
    output logic                            hang_o,
    output logic [1:0]                      state_o
);

    state_e                  state_q, state_d;
    logic                    out_valid_q, out_valid_d;
    logic [CW-1:0]           out_core_q, out_core_d;
    commit_t                 out_commit_q, out_commit_d;
    logic [CW-1:0]           last_q, last_d;
    logic [NUM_CORES-1:0]    overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0]   drop_q, drop_d;
    logic                    hang_q, hang_d;
    logic [WW-1:0]           wdog_q, wdog_d;

    logic [NUM_CORES-1:0]    push, pop, drop, full_w, empty_w;
    commit_t                 fifo_data [NUM_CORES];
    logic [CW-1:0]           grant, hi_g, lo_g;
    logic                    any_ne, hi_ok, lo_ok;
    logic                    run, slot_free, any_push, expire, all_empty;
    logic [6:0]              n_drop;
    logic [DROP_CNT_W:0]     drop_sum;

    for (genvar c = 0; c < NUM_CORES; c++) begin : g_fifo
        cosim_commit_fifo #(
            .DEPTH (FIFO_DEPTH),
            .T     (commit_t)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .push_i  (push[c]),
            .data_i  (commit_i[c]),
            .pop_i   (pop[c]),
            .data_o  (fifo_data[c]),
            .full_o  (full_w[c]),
            .empty_o (empty_w[c])
        );
    end

    // Round-robin: lowest non-empty core above the last grant wins, otherwise
    // wrap to the lowest non-empty core at or below it.
    always_comb begin
        hi_ok = 1'b0;
        lo_ok = 1'b0;
        hi_g  = '0;
        lo_g  = '0;
        for (int c = NUM_CORES - 1; c >= 0; c--) begin
            if (!empty_w[c]) begin
                if (CW'(c) > last_q) begin
                    hi_ok = 1'b1;
                    hi_g  = CW'(c);
                end else begin
                    lo_ok = 1'b1;
                    lo_g  = CW'(c);
                end
            end
        end
        any_ne = hi_ok || lo_ok;
        grant  = hi_ok ? hi_g : lo_g;
    end

    always_comb begin
        run       = state_q == RUN;
        slot_free = !out_valid_q || out_ready_i;
        any_push  = 1'b0;
        n_drop    = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            pop[c]   = slot_free && any_ne && (grant == CW'(c));
            push[c]  = run && commit_valid_i[c] && (!full_w[c] || pop[c]);
            drop[c]  = run && commit_valid_i[c] && !push[c];
            any_push = any_push || push[c];
            n_drop   = n_drop + 7'(drop[c]);
        end
        overflow_d   = overflow_q | drop;
        drop_sum     = (DROP_CNT_W+1)'(drop_q) + (DROP_CNT_W+1)'(n_drop);
        drop_d       = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
        out_valid_d  = slot_free ? any_ne : out_valid_q;
        out_core_d   = (slot_free && any_ne) ? grant : out_core_q;
        out_commit_d = (slot_free && any_ne) ? fifo_data[grant] : out_commit_q;
        last_d       = (slot_free && any_ne) ? grant : last_q;
        wdog_d       = (!run || any_push) ? '0 : wdog_q + 1'b1;
        expire       = run && (wdog_d == WW'(WDOG_CYCLES));
        hang_d       = hang_q || expire;
        all_empty    = &empty_w;
        state_d      = expire                                           ? HANG
                     : (state_q == IDLE  && enable_i)                   ? RUN
                     : (state_q == RUN   && !enable_i)                  ? DRAIN
                     : (state_q == DRAIN && enable_i)                   ? RUN
                     : (state_q == DRAIN && all_empty && !out_valid_q)  ? IDLE
                     : state_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
            out_core_q   <= '0;
            out_commit_q <= '0;
            last_q       <= CW'(NUM_CORES - 1);
            overflow_q   <= '0;
            drop_q       <= '0;
            hang_q       <= 1'b0;
            wdog_q       <= '0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_core_q   <= out_core_d;
            out_commit_q <= out_commit_d;
            last_q       <= last_d;
            overflow_q   <= overflow_d;
            drop_q       <= drop_d;
            hang_q       <= hang_d;
            wdog_q       <= wdog_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_core_o   = out_core_q;
    assign out_commit_o = out_commit_q;
    assign overflow_o   = overflow_q;
    assign drop_cnt_o   = drop_q;
    assign hang_o       = hang_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_cosim_commit_collector.sv
// tb_cosim_commit_collector: randomized and directed checks of the commit collector against a queue-based model.
module tb_cosim_commit_collector;
    import cosim_commit_pkg::*;

    localparam int NC = 3;
    localparam int D  = 8;
    localparam int W  = 16;

    logic                   clk_i = 1'b0;
    logic                   rst_ni = 1'b0;
    logic                   enable_i = 1'b0;
    logic [NC-1:0]          commit_valid_i = '0;
    commit_t [NC-1:0]       commit_i = '0;
    logic                   out_valid_o;
    logic                   out_ready_i = 1'b0;
    logic [1:0]             out_core_o;
    commit_t                out_commit_o;
    logic [NC-1:0]          overflow_o;
    logic [15:0]            drop_cnt_o;
    logic                   hang_o;
    logic [1:0]             state_o;

    cosim_commit_collector #(
        .NUM_CORES   (NC),
        .FIFO_DEPTH  (D),
        .WDOG_CYCLES (W)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .enable_i       (enable_i),
        .commit_valid_i (commit_valid_i),
        .commit_i       (commit_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_core_o     (out_core_o),
        .out_commit_o   (out_commit_o),
        .overflow_o     (overflow_o),
        .drop_cnt_o     (drop_cnt_o),
        .hang_o         (hang_o),
        .state_o        (state_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: per-core queues, one output slot, plain counters.
    commit_t   mq [NC][$];
    int        ms, mlast, mwd, mdrop, mcore;
    bit        mv, mhang;
    bit [NC-1:0] movf;
    commit_t   mdata;
    logic [63:0] pcs [NC];

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) mq[c].delete();
        ms = 0; mlast = NC - 1; mwd = 0; mdrop = 0; mcore = 0;
        mv = 0; mhang = 0; movf = '0; mdata = '0;
    endtask

    task automatic model_step();
        int g, pre;
        bit free_s, idle_ok, pushed;
        pre = ms;
        idle_ok = !mv;
        for (int c = 0; c < NC; c++) if (mq[c].size() != 0) idle_ok = 0;
        free_s = !mv || out_ready_i;
        g = -1;
        for (int i = 1; i <= NC; i++) if (g < 0 && mq[(mlast + i) % NC].size() != 0) g = (mlast + i) % NC;
        if (free_s) begin
            mv = g >= 0;
            if (g >= 0) begin
                mcore = g;
                mdata = mq[g].pop_front();
                mlast = g;
            end
        end
        pushed = 0;
        if (pre == 1) begin
            for (int c = 0; c < NC; c++) begin
                if (commit_valid_i[c]) begin
                    if (mq[c].size() < D) begin
                        mq[c].push_back(commit_i[c]);
                        pushed = 1;
                    end else begin
                        movf[c] = 1;
                        if (mdrop < 65535) mdrop++;
                    end
                end
            end
        end
        mwd = (pre == 1 && !pushed) ? mwd + 1 : 0;
        if (mwd == W) mhang = 1;
        if (pre == 0) ms = enable_i ? 1 : 0;
        else if (pre == 1) ms = (mwd == W) ? 3 : (enable_i ? 1 : 2);
        else if (pre == 2) ms = enable_i ? 1 : (idle_ok ? 0 : 2);
    endtask

    task automatic compare_all();
        check("state", state_o, ms);
        check("hang", hang_o, mhang);
        check("overflow", overflow_o, movf);
        check("drop_cnt", drop_cnt_o, mdrop);
        check("out_valid", out_valid_o, mv);
        if (mv) begin
            check("out_core", out_core_o, mcore);
            check("out_commit", out_commit_o, mdata);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
        compare_all();
    endtask

    function automatic commit_t rnd_commit(input logic [63:0] pc);
        logic [191:0] r;
        commit_t x;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        x = r[172:0];
        x.pc = pc;
        return x;
    endfunction

    task automatic set_commits(input logic [NC-1:0] v);
        commit_valid_i = v;
        for (int c = 0; c < NC; c++) begin
            commit_i[c] = rnd_commit(pcs[c]);
            if (v[c]) pcs[c] = pcs[c] + 64'd4;
        end
    endtask

    task automatic do_reset();
        #2 rst_ni = 1'b0;
        #1;
        model_reset();
        check("rst_valid", out_valid_o, 0);
        check("rst_core", out_core_o, 0);
        check("rst_commit", out_commit_o, 0);
        check("rst_ovf", overflow_o, 0);
        check("rst_drop", drop_cnt_o, 0);
        check("rst_hang", hang_o, 0);
        check("rst_state", state_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        for (int c = 0; c < NC; c++) pcs[c] = 64'h8000_0000 + 64'(c) * 64'h1_0000;
        model_reset();
        repeat (2) @(negedge clk_i);
        compare_all();
        check("rst_core", out_core_o, 0);
        check("rst_commit", out_commit_o, 0);
        rst_ni = 1'b1;

        // Three back-to-back commits on core 0, consumer always ready.
        enable_i = 1'b1; out_ready_i = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin set_commits(3'b001); tick(); end
        set_commits(3'b000);
        repeat (3) tick();

        // Overflow on core 0 with the consumer stalled, then release.
        out_ready_i = 1'b0;
        for (int k = 0; k < 10; k++) begin set_commits(3'b001); tick(); end
        set_commits(3'b000);
        tick();
        out_ready_i = 1'b1;
        repeat (12) tick();

        // Round-robin: every core commits every cycle.
        for (int k = 0; k < 6; k++) begin set_commits(3'b111); tick(); end
        set_commits(3'b000);
        repeat (14) tick();

        // Backpressure: four pending records, ready toggling.
        out_ready_i = 1'b0;
        set_commits(3'b110); tick();
        set_commits(3'b110); tick();
        set_commits(3'b000);
        for (int k = 0; k < 12; k++) begin out_ready_i = ~out_ready_i; tick(); end
        out_ready_i = 1'b1;
        tick();

        // Random traffic with occasional enable toggles.
        for (int k = 0; k < 400; k++) begin
            logic [NC-1:0] v;
            for (int c = 0; c < NC; c++) v[c] = $urandom_range(0, 9) < 6;
            set_commits(v);
            out_ready_i = $urandom_range(0, 9) < 7;
            if ($urandom_range(0, 19) == 0) enable_i = ~enable_i;
            tick();
        end

        // Watchdog: no commits while running.
        do_reset();
        compare_all();
        enable_i = 1'b1; out_ready_i = 1'b1;
        set_commits(3'b000);
        repeat (20) tick();
        set_commits(3'b011);
        repeat (2) tick();
        set_commits(3'b000);
        repeat (2) tick();

        // Asynchronous reset with records pending; nothing emerges afterwards.
        do_reset();
        enable_i = 1'b1; out_ready_i = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin set_commits(3'b001); tick(); end
        set_commits(3'b000);
        enable_i = 1'b0;
        do_reset();
        out_ready_i = 1'b1;
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
